pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised fetch-stage PC sequencer; successor to the combinational next-PC mux.
//   Owns the PC register, picks the next PC by fixed priority, and latches redirect
//   strobes that arrive while fetch is stalled. Flags bad fetch addresses for the
//   exception unit. Sits between the hazard/exception control and the instruction memory.
// PARAMETERS
//   WIDTH     32            PC / target width in bits
//   RESET_PC  32'h0000_3000 PC value after reset
//   EXC_PC    32'h0000_4180 exception entry vector
//   PC_LIMIT  32'h0000_6FFC highest legal fetch address (inclusive)
// PORTS
//   clk           in   1      clock, all state updates on rising edge
//   reset         in   1      synchronous, active-high
//   stall         in   1      1 = hold PC this cycle (hazard or imem not ready)
//   br_taken      in   1      one-cycle strobe: conditional branch taken
//   br_target     in   WIDTH  branch target
//   jmp           in   1      one-cycle strobe: j / jal
//   jmp_target    in   WIDTH  j / jal target
//   jr            in   1      one-cycle strobe: jr / jalr
//   jr_target     in   WIDTH  register target
//   exc           in   1      one-cycle strobe: take exception
//   eret          in   1      one-cycle strobe: return from exception
//   epc           in   WIDTH  eret return address
//   pc            out  WIDTH  current fetch address (registered)
//   pc_plus8      out  WIDTH  pc + 8, link value (combinational)
//   pending       out  1      1 = a captured redirect awaits commit
//   addr_err      out  1      registered: pc misaligned or outside [RESET_PC, PC_LIMIT]
// BEHAVIOUR
//   - Reset: pc=RESET_PC, pending=0, pend_pc=0, addr_err=0, state=RUN. Reset wins
//     over every other input; a pending redirect is discarded.
//   - Priority (high->low): exc > eret > br_taken > jmp > jr > pending > pc+4.
//     exc selects EXC_PC, eret selects epc. Multiple strobes in one cycle: highest only.
//   - Arithmetic: pc+4 and pc+8 modulo 2^WIDTH; wrap-around is silent.
//   - States (1-bit): RUN, HOLD. pend_pri records priority of the captured redirect.
//   - RUN, stall=0: pc <= selected next PC; stay RUN.
//   - RUN, stall=1, any strobe: pend_pc <= selected target, pend_pri <= its priority,
//     go HOLD; pc unchanged. No strobe: pc unchanged, stay RUN.
//   - HOLD, stall=1: new strobe with priority >= pend_pri overwrites pend_pc
//     (equal priority: newest wins); lower priority ignored. pc unchanged.
//   - HOLD, stall=0: new strobe with priority >= pend_pri commits directly; else
//     pc <= pend_pc. Either way go RUN, pending clears same edge.
//   - pending = (state==HOLD). Latency: unstalled redirect visible on pc next cycle;
//     stalled redirect visible the cycle after stall first deasserts.
//   - addr_err is computed from the value being loaded into pc, so it is aligned with
//     pc: 1 when next_pc[1:0]!=0, next_pc<RESET_PC or next_pc>PC_LIMIT. PC still
//     loads the bad value; the exception unit responds with exc.
//   - No X on outputs after reset; strobe inputs are sampled only on clock edges.
// TESTING
//   1 reset 2 cycles, stall=0, no strobes -> pc 0x3000,0x3004,0x3008,0x300C; pc_plus8=pc+8
//   2 stall=1, br_taken pulse (target 0x3100), stall held 2 more cycles -> pc held,
//     pending=1; first stall=0 cycle -> next pc=0x3100, pending=0
//   3 same cycle exc=1, br_taken=1, jmp=1, stall=0 -> pc=0x4180
//   4 HOLD with branch 0x3100, then exc while stalled -> on release pc=0x4180;
//     HOLD with exc, then jr while stalled -> on release pc=0x4180 (jr ignored)
//   5 eret epc=0x3002, stall=0 -> pc=0x3002, addr_err=1; jmp_target 0x7000 -> addr_err=1
//   6 HOLD with pending branch, reset=1 one cycle -> pc=0x3000, pending=0, next pc=0x3004

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between hazard/exception control (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jmp;
  logic [WIDTH-1:0] jmp_target;
  logic             jr;
  logic [WIDTH-1:0] jr_target;
  logic             exc;
  logic             eret;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus8;
  logic             pending;
  logic             addr_err;

  modport master (
    output stall, br_taken, br_target, jmp, jmp_target, jr, jr_target, exc, eret, epc,
    input  pc, pc_plus8, pending, addr_err
  );

  modport slave (
    input  stall, br_taken, br_target, jmp, jmp_target, jr, jr_target, exc, eret, epc,
    output pc, pc_plus8, pending, addr_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register with fixed-priority next-PC select; redirects seen under stall are held
// and land one cycle after stall drops, unstalled redirects land on the next edge.
module pc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0] PC_LIMIT = WIDTH'(32'h0000_6FFC)
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  // 0 means "no strobe"; larger value wins
  localparam logic [2:0] PRI_NONE = 3'd0;
  localparam logic [2:0] PRI_JR   = 3'd1;
  localparam logic [2:0] PRI_JMP  = 3'd2;
  localparam logic [2:0] PRI_BR   = 3'd3;
  localparam logic [2:0] PRI_ERET = 3'd4;
  localparam logic [2:0] PRI_EXC  = 3'd5;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_pc;
  logic [2:0]       pend_pri;
  logic             addr_err_q;

  logic [2:0]       req_pri;
  logic [WIDTH-1:0] req_tgt;
  logic             req_vld;
  logic             take_new;
  logic             pc_load;
  logic             pend_load;
  logic [WIDTH-1:0] next_pc;
  logic             addr_bad;

  always_comb begin
    req_pri = PRI_NONE;
    req_tgt = '0;
    if (bus.exc) begin
      req_pri = PRI_EXC;
      req_tgt = EXC_PC;
    end else if (bus.eret) begin
      req_pri = PRI_ERET;
      req_tgt = bus.epc;
    end else if (bus.br_taken) begin
      req_pri = PRI_BR;
      req_tgt = bus.br_target;
    end else if (bus.jmp) begin
      req_pri = PRI_JMP;
      req_tgt = bus.jmp_target;
    end else if (bus.jr) begin
      req_pri = PRI_JR;
      req_tgt = bus.jr_target;
    end
  end

  assign req_vld  = (req_pri != PRI_NONE);
  // Equal priority counts as a win so the newest strobe replaces a held one
  assign take_new = req_vld && (req_pri >= pend_pri);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.stall && req_vld) state_nxt = HOLD;
      HOLD:    if (!bus.stall)           state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_load   = 1'b0;
    pend_load = 1'b0;
    next_pc   = pc_q + WIDTH'(4);
    case (state)
      RUN: begin
        if (!bus.stall) begin
          pc_load = 1'b1;
          if (req_vld) next_pc = req_tgt;
        end else begin
          pend_load = req_vld;
        end
      end
      HOLD: begin
        if (bus.stall) begin
          pend_load = take_new;
        end else begin
          pc_load = 1'b1;
          next_pc = take_new ? req_tgt : pend_pc;
        end
      end
      default: ;
    endcase
  end

  // Judged on the value being loaded so the flag lines up with the registered pc
  assign addr_bad = (next_pc[1:0] != 2'b00) || (next_pc < RESET_PC) || (next_pc > PC_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_pc    <= '0;
      pend_pri   <= PRI_NONE;
      addr_err_q <= 1'b0;
    end else begin
      if (pc_load) begin
        pc_q       <= next_pc;
        addr_err_q <= addr_bad;
      end
      if (pend_load) begin
        pend_pc  <= req_tgt;
        pend_pri <= req_pri;
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus8 = pc_q + WIDTH'(8);
  assign bus.pending  = (state == HOLD);
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a rule-level model checked every cycle plus literal pins.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_V  = 32'h0000_4180;
  localparam logic [31:0] LIMIT  = 32'h0000_6FFC;

  // strobe vector bit order = priority order, highest bit wins
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_JR   = 5'b00001;
  localparam logic [4:0] S_JMP  = 5'b00010;
  localparam logic [4:0] S_BR   = 5'b00100;
  localparam logic [4:0] S_ERET = 5'b01000;
  localparam logic [4:0] S_EXC  = 5'b10000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus();

  pc_sequencer #(
    .WIDTH(32), .RESET_PC(RST_PC), .EXC_PC(EXC_V), .PC_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  bit          m_pend;
  int          m_pend_pri;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < RST_PC) || (a > LIMIT);
  endfunction

  task automatic model_update(input bit rst, input bit stl, input logic [4:0] stb,
                              input logic [31:0] bt, input logic [31:0] jt,
                              input logic [31:0] rt, input logic [31:0] ep);
    logic [31:0] tg [5];
    int          best;
    tg[0] = rt; tg[1] = jt; tg[2] = bt; tg[3] = ep; tg[4] = EXC_V;
    best = -1;
    for (int i = 0; i < 5; i++) if (stb[i]) best = i;
    if (rst) begin
      m_pc = RST_PC; m_pend = 0; m_pend_pc = '0; m_pend_pri = -1; m_err = 0;
    end else if (!m_pend) begin
      if (!stl) begin
        m_pc  = (best >= 0) ? tg[best] : m_pc + 32'd4;
        m_err = bad_addr(m_pc);
      end else if (best >= 0) begin
        m_pend = 1; m_pend_pc = tg[best]; m_pend_pri = best;
      end
    end else if (stl) begin
      if (best >= 0 && best >= m_pend_pri) begin
        m_pend_pc = tg[best]; m_pend_pri = best;
      end
    end else begin
      m_pc   = (best >= 0 && best >= m_pend_pri) ? tg[best] : m_pend_pc;
      m_err  = bad_addr(m_pc);
      m_pend = 0;
    end
  endtask

  task automatic step(input bit rst, input bit stl, input logic [4:0] stb,
                      input logic [31:0] bt = 32'h0, input logic [31:0] jt = 32'h0,
                      input logic [31:0] rt = 32'h0, input logic [31:0] ep = 32'h0);
    reset          = rst;
    bus.stall      = stl;
    bus.exc        = stb[4];
    bus.eret       = stb[3];
    bus.br_taken   = stb[2];
    bus.jmp        = stb[1];
    bus.jr         = stb[0];
    bus.br_target  = bt;
    bus.jmp_target = jt;
    bus.jr_target  = rt;
    bus.epc        = ep;
    @(posedge clk);
    model_update(rst, stl, stb, bt, jt, rt, ep);
    #2;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("pc",       bus.pc,                  m_pc);
      chk("pc_plus8", bus.pc_plus8,            m_pc + 32'd8);
      chk("pending",  {31'd0, bus.pending},    {31'd0, m_pend});
      chk("addr_err", {31'd0, bus.addr_err},   {31'd0, m_err});
    end
  end

  initial begin
    step(1, 0, S_NONE);
    step(1, 0, S_NONE);
    check_en = 1'b1;
    chk("rst_pc",      bus.pc,                32'h3000);
    chk("rst_pending", {31'd0, bus.pending},  32'd0);
    chk("rst_err",     {31'd0, bus.addr_err}, 32'd0);

    // sequential fetch
    step(0, 0, S_NONE);
    chk("seq_pc1", bus.pc, 32'h3004);
    step(0, 0, S_NONE);
    step(0, 0, S_NONE);
    chk("seq_pc3",    bus.pc,       32'h300C);
    chk("seq_plus8",  bus.pc_plus8, 32'h3014);

    // branch captured under stall, released later
    step(0, 1, S_BR, 32'h3100);
    step(0, 1, S_NONE);
    step(0, 1, S_NONE);
    chk("hold_pc",      bus.pc,               32'h300C);
    chk("hold_pending", {31'd0, bus.pending}, 32'd1);
    step(0, 0, S_NONE);
    chk("rel_pc",      bus.pc,               32'h3100);
    chk("rel_pending", {31'd0, bus.pending}, 32'd0);

    // simultaneous strobes, unstalled
    step(0, 0, S_EXC | S_BR | S_JMP, 32'h3200, 32'h3300);
    chk("multi_pc", bus.pc, 32'h4180);
    step(0, 0, S_BR | S_JMP | S_JR, 32'h3210, 32'h3220, 32'h3230);
    chk("br_over_jmp", bus.pc, 32'h3210);

    // higher priority overrides held branch
    step(0, 1, S_BR, 32'h3100);
    step(0, 1, S_EXC);
    step(0, 0, S_NONE);
    chk("exc_over_br", bus.pc, 32'h4180);
    // lower priority ignored while exc held
    step(0, 1, S_EXC);
    step(0, 1, S_JR, 32'h0, 32'h0, 32'h3200);
    step(0, 0, S_NONE);
    chk("jr_ignored", bus.pc, 32'h4180);
    // equal priority: newest wins
    step(0, 1, S_BR, 32'h3500);
    step(0, 1, S_BR, 32'h3600);
    step(0, 0, S_NONE);
    chk("br_newest", bus.pc, 32'h3600);
    // release cycle with a stronger strobe commits it directly
    step(0, 1, S_JR, 32'h0, 32'h0, 32'h3300);
    step(0, 0, S_BR, 32'h3400);
    chk("rel_strobe", bus.pc, 32'h3400);
    // release cycle with a weaker strobe takes the held target
    step(0, 1, S_JMP, 32'h0, 32'h3700);
    step(0, 0, S_JR, 32'h0, 32'h0, 32'h3800);
    chk("rel_weak", bus.pc, 32'h3700);

    // address errors
    step(0, 0, S_ERET, 32'h0, 32'h0, 32'h0, 32'h3002);
    chk("eret_pc",  bus.pc,                32'h3002);
    chk("eret_err", {31'd0, bus.addr_err}, 32'd1);
    step(0, 0, S_JMP, 32'h0, 32'h7000);
    chk("hi_err", {31'd0, bus.addr_err}, 32'd1);
    step(0, 0, S_JMP, 32'h0, 32'h6FFC);
    chk("limit_ok", {31'd0, bus.addr_err}, 32'd0);
    step(0, 0, S_NONE);
    chk("over_limit", {31'd0, bus.addr_err}, 32'd1);
    step(0, 0, S_JR, 32'h0, 32'h0, 32'h2FFC);
    chk("lo_err", {31'd0, bus.addr_err}, 32'd1);
    step(0, 0, S_NONE);
    chk("lo_edge_ok", {31'd0, bus.addr_err}, 32'd0);

    // modular wrap
    step(0, 0, S_JMP, 32'h0, 32'hFFFF_FFFC);
    chk("wrap_plus8", bus.pc_plus8, 32'h0000_0004);
    step(0, 0, S_NONE);
    chk("wrap_pc", bus.pc, 32'h0000_0000);

    // reset discards a held redirect
    step(0, 1, S_BR, 32'h3100);
    step(1, 1, S_NONE);
    chk("rst_hold_pc",      bus.pc,               32'h3000);
    chk("rst_hold_pending", {31'd0, bus.pending}, 32'd0);
    step(0, 0, S_NONE);
    chk("rst_next_pc", bus.pc, 32'h3004);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
